operand_pair_sequencer: RTL and testbench

//   Upstream stimulus stage for the 2-bit a/b operand consumer.
//   On start, sweeps every (a,b) operand pair in order: a is the MSB half of the pair index, b is the LSB half.

---
 rtl/operand_pair_sequencer_pkg.sv | 17 +
 rtl/operand_pair_sequencer_if.sv | 25 ++
 rtl/operand_pair_sequencer_hold_timer.sv | 29 ++
 rtl/operand_pair_sequencer.sv | 126 ++++++++++++
 tb/tb_operand_pair_sequencer.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/operand_pair_sequencer_pkg.sv
// Shared definitions for the operand pair sequencer: FSM state encoding and
// the terminal pair-index test.
package operand_pair_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OFFER = 2'd1,
        ST_HOLD  = 2'd2,
        ST_FIN   = 2'd3
    } state_t;

    // True when idx is the last pair of a sweep over pair_bits-wide indices.
    function automatic logic is_last_pair(input logic [31:0] idx, input int unsigned pair_bits);
        return idx == ((32'd1 << pair_bits) - 32'd1);
    endfunction

endpackage

// File: rtl/operand_pair_sequencer_if.sv
// Control and operand bundle between the sequencer (master) and whoever
// drives its controls and consumes its operands (slave).
interface operand_pair_sequencer_if #(
    parameter int WIDTH = 2
);
    logic                   start;
    logic                   stop;
    logic                   ready;
    logic [WIDTH-1:0]       a;
    logic [WIDTH-1:0]       b;
    logic                   valid;
    logic                   busy;
    logic                   done;
    logic [2*WIDTH-1:0]     idx;

    modport master (
        input  start, stop, ready,
        output a, b, valid, busy, done, idx
    );

    modport slave (
        output start, stop, ready,
        input  a, b, valid, busy, done, idx
    );
endinterface

// File: rtl/operand_pair_sequencer_hold_timer.sv
// Loadable down-counter that times how long an accepted pair stays stable.
// Saturates at zero; zero flag is combinational from the count.
module hold_timer #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             dec,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] value,
    output logic             zero
);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its inputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= '0;
        end else if (load) begin
            value <= load_value;
        end else if (dec && value != '0) begin
            value <= value - 1'b1;
        end
    end

    assign zero = (value == '0);

endmodule

// File: rtl/operand_pair_sequencer.sv
// Sweeps every (a,b) operand pair in index order, offering each with a
// valid/ready handshake and then holding it stable for HOLD_CYCLES cycles.
module operand_pair_sequencer
    import operand_pair_sequencer_pkg::*;
#(
    parameter int WIDTH       = 2,
    parameter int HOLD_CYCLES = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    operand_pair_sequencer_if.master bus
);

    localparam int PAIR_BITS = 2 * WIDTH;
    localparam int TIMER_W   = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
    localparam logic [TIMER_W-1:0] HOLD_LOAD =
        (HOLD_CYCLES > 0) ? TIMER_W'(HOLD_CYCLES - 1) : '0;

    state_t                 state_q, state_d;
    logic [PAIR_BITS-1:0]   idx_q, idx_d;
    logic                   valid_q, valid_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   advance;
    logic                   last_pair;
    logic                   timer_load, timer_dec, timer_zero;
    logic [TIMER_W-1:0]     timer_value;

    hold_timer #(.WIDTH(TIMER_W)) u_hold_timer (
        .clk        (clk),
        .rst        (rst),
        .load       (timer_load),
        .dec        (timer_dec),
        .load_value (HOLD_LOAD),
        .value      (timer_value),
        .zero       (timer_zero)
    );

    assign last_pair = is_last_pair(32'(idx_q), PAIR_BITS);

    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        valid_d    = valid_q;
        done_d     = 1'b0;
        advance    = 1'b0;
        timer_load = 1'b0;
        timer_dec  = 1'b0;

        if (state_q != ST_IDLE && bus.stop) begin
            state_d = ST_IDLE;
            idx_d   = '0;
            valid_d = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (bus.start && !bus.stop) begin
                        state_d = ST_OFFER;
                        idx_d   = '0;
                        valid_d = 1'b1;
                    end
                end
                ST_OFFER: begin
                    if (valid_q && bus.ready) begin
                        valid_d = 1'b0;
                        if (HOLD_CYCLES > 0) begin
                            state_d    = ST_HOLD;
                            timer_load = 1'b1;
                        end else begin
                            advance = 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (timer_zero) advance   = 1'b1;
                    else            timer_dec = 1'b1;
                end
                ST_FIN: begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                end
                default: state_d = ST_IDLE;
            endcase

            // Terminal compare happens before the increment, so idx never wraps.
            if (advance) begin
                if (last_pair) begin
                    state_d = ST_FIN;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_OFFER;
                    idx_d   = idx_q + 1'b1;
                    valid_d = 1'b1;
                end
            end
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.idx   = idx_q;
    assign bus.a     = idx_q[PAIR_BITS-1:WIDTH];
    assign bus.b     = idx_q[WIDTH-1:0];
    assign bus.valid = valid_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;

endmodule

// File: tb/tb_operand_pair_sequencer.sv
// Directed bench for operand_pair_sequencer: one instance with a 5-cycle hold
// and one with no hold, sharing clock and reset.
module tb_operand_pair_sequencer;

    logic clk;
    logic rst;
    int   tests_run;
    int   tests_failed;

    operand_pair_sequencer_if #(.WIDTH(2)) bus5 ();
    operand_pair_sequencer_if #(.WIDTH(2)) bus0 ();

    operand_pair_sequencer #(.WIDTH(2), .HOLD_CYCLES(5)) dut5 (
        .clk (clk),
        .rst (rst),
        .bus (bus5)
    );

    operand_pair_sequencer #(.WIDTH(2), .HOLD_CYCLES(0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Pulses start5 across one rising edge (edge 1 of the sweep).
    task automatic start5();
        bus5.start = 1'b1;
        tick();
        bus5.start = 1'b0;
    endtask

    task automatic stop5();
        bus5.stop = 1'b1;
        tick();
        bus5.stop = 1'b0;
    endtask

    // {a, b, idx, valid, busy, done}
    function automatic logic [10:0] snap5();
        return {bus5.a, bus5.b, bus5.idx, bus5.valid, bus5.busy, bus5.done};
    endfunction

    function automatic logic [10:0] snap0();
        return {bus0.a, bus0.b, bus0.idx, bus0.valid, bus0.busy, bus0.done};
    endfunction

    function automatic logic [10:0] exp_pair(input logic [3:0] p, input logic v,
                                             input logic bz, input logic d);
        return {p[3:2], p[1:0], p, v, bz, d};
    endfunction

    task automatic test_reset();
        logic [10:0] got;
        rst = 1'b1;
        ticks(2);
        got = snap5();
        tests_run++;
        if (got !== 11'd0) begin
            tests_failed++;
            $display("FAIL reset_state_hold5: got %b want %b", got, 11'd0);
        end
        got = snap0();
        tests_run++;
        if (got !== 11'd0) begin
            tests_failed++;
            $display("FAIL reset_state_hold0: got %b want %b", got, 11'd0);
        end
        rst = 1'b0;
        tick();

        // Reach pair 5 in OFFER (edge 31) and stall it there.
        bus5.ready = 1'b1;
        start5();
        ticks(30);
        bus5.ready = 1'b0;
        tick();
        got = snap5();
        tests_run++;
        if (got !== exp_pair(4'd5, 1'b1, 1'b1, 1'b0)) begin
            tests_failed++;
            $display("FAIL reset_pre_offer5: got %b want %b", got, exp_pair(4'd5, 1'b1, 1'b1, 1'b0));
        end

        #2 rst = 1'b1;
        #1;
        got = snap5();
        tests_run++;
        if (got !== 11'd0) begin
            tests_failed++;
            $display("FAIL reset_async_mid_offer: got %b want %b", got, 11'd0);
        end
        tick();
        rst = 1'b0;
        ticks(2);
        got = snap5();
        tests_run++;
        if (got !== 11'd0) begin
            tests_failed++;
            $display("FAIL reset_after_release: got %b want %b", got, 11'd0);
        end
        bus5.ready = 1'b1;
    endtask

    task automatic test_full_sweep();
        logic [10:0] got, exp;
        logic [3:0]  p;
        int          phase;
        bus5.ready = 1'b1;
        start5();
        for (int e = 1; e <= 98; e++) begin
            if (e > 1) tick();
            if (e <= 96) begin
                p     = 4'((e - 1) / 6);
                phase = (e - 1) % 6;
                exp   = exp_pair(p, phase == 0, 1'b1, 1'b0);
            end else if (e == 97) begin
                exp = exp_pair(4'd15, 1'b0, 1'b1, 1'b1);
            end else begin
                exp = 11'd0;
            end
            got = snap5();
            tests_run++;
            if (got !== exp) begin
                tests_failed++;
                $display("FAIL full_sweep edge %0d: got %b want %b", e, got, exp);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [10:0] got;
        bus5.ready = 1'b1;
        start5();
        ticks(12);
        bus5.ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            got = snap5();
            tests_run++;
            if (got !== exp_pair(4'd2, 1'b1, 1'b1, 1'b0)) begin
                tests_failed++;
                $display("FAIL backpressure_stall cycle %0d: got %b want %b",
                         i, got, exp_pair(4'd2, 1'b1, 1'b1, 1'b0));
            end
        end
        bus5.ready = 1'b1;
        tick();
        got = snap5();
        tests_run++;
        if (got !== exp_pair(4'd2, 1'b0, 1'b1, 1'b0)) begin
            tests_failed++;
            $display("FAIL backpressure_accept: got %b want %b", got, exp_pair(4'd2, 1'b0, 1'b1, 1'b0));
        end
        ticks(4);
        got = snap5();
        tests_run++;
        if (got !== exp_pair(4'd2, 1'b0, 1'b1, 1'b0)) begin
            tests_failed++;
            $display("FAIL backpressure_hold_end: got %b want %b", got, exp_pair(4'd2, 1'b0, 1'b1, 1'b0));
        end
        tick();
        got = snap5();
        tests_run++;
        if (got !== exp_pair(4'd3, 1'b1, 1'b1, 1'b0)) begin
            tests_failed++;
            $display("FAIL backpressure_next_pair: got %b want %b", got, exp_pair(4'd3, 1'b1, 1'b1, 1'b0));
        end
        stop5();
    endtask

    task automatic test_abort();
        logic [10:0] got;
        bus5.ready = 1'b1;
        start5();
        ticks(56);
        got = snap5();
        tests_run++;
        if (got !== exp_pair(4'd9, 1'b0, 1'b1, 1'b0)) begin
            tests_failed++;
            $display("FAIL abort_in_hold9: got %b want %b", got, exp_pair(4'd9, 1'b0, 1'b1, 1'b0));
        end
        stop5();
        got = snap5();
        tests_run++;
        if (got !== 11'd0) begin
            tests_failed++;
            $display("FAIL abort_to_idle: got %b want %b", got, 11'd0);
        end
        for (int i = 0; i < 8; i++) begin
            tick();
            tests_run++;
            if (bus5.done !== 1'b0 || bus5.busy !== 1'b0) begin
                tests_failed++;
                $display("FAIL abort_stays_idle cycle %0d: done=%b busy=%b want 0 0",
                         i, bus5.done, bus5.busy);
            end
        end
        start5();
        got = snap5();
        tests_run++;
        if (got !== exp_pair(4'd0, 1'b1, 1'b1, 1'b0)) begin
            tests_failed++;
            $display("FAIL abort_restart: got %b want %b", got, exp_pair(4'd0, 1'b1, 1'b1, 1'b0));
        end
        stop5();
    endtask

    task automatic test_corners();
        logic [10:0] got;
        bus5.start = 1'b1;
        bus5.stop  = 1'b1;
        tick();
        got = snap5();
        tests_run++;
        if (got !== 11'd0) begin
            tests_failed++;
            $display("FAIL start_stop_together: got %b want %b", got, 11'd0);
        end
        bus5.start = 1'b0;
        bus5.stop  = 1'b0;
        tick();
        got = snap5();
        tests_run++;
        if (got !== 11'd0) begin
            tests_failed++;
            $display("FAIL start_stop_after: got %b want %b", got, 11'd0);
        end

        bus5.ready = 1'b1;
        start5();
        ticks(7);
        start5();
        got = snap5();
        tests_run++;
        if (got !== exp_pair(4'd1, 1'b0, 1'b1, 1'b0)) begin
            tests_failed++;
            $display("FAIL start_busy_hold: got %b want %b", got, exp_pair(4'd1, 1'b0, 1'b1, 1'b0));
        end
        ticks(3);
        start5();
        got = snap5();
        tests_run++;
        if (got !== exp_pair(4'd2, 1'b1, 1'b1, 1'b0)) begin
            tests_failed++;
            $display("FAIL start_busy_offer: got %b want %b", got, exp_pair(4'd2, 1'b1, 1'b1, 1'b0));
        end
        tick();
        got = snap5();
        tests_run++;
        if (got !== exp_pair(4'd2, 1'b0, 1'b1, 1'b0)) begin
            tests_failed++;
            $display("FAIL start_busy_after: got %b want %b", got, exp_pair(4'd2, 1'b0, 1'b1, 1'b0));
        end
        stop5();
    endtask

    task automatic test_no_hold();
        logic [10:0] got, exp;
        bus0.ready = 1'b1;
        bus0.start = 1'b1;
        tick();
        bus0.start = 1'b0;
        for (int e = 1; e <= 18; e++) begin
            if (e > 1) tick();
            if (e <= 16)      exp = exp_pair(4'(e - 1), 1'b1, 1'b1, 1'b0);
            else if (e == 17) exp = exp_pair(4'd15, 1'b0, 1'b1, 1'b1);
            else              exp = 11'd0;
            got = snap0();
            tests_run++;
            if (got !== exp) begin
                tests_failed++;
                $display("FAIL no_hold edge %0d: got %b want %b", e, got, exp);
            end
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b1;
        bus5.start   = 1'b0;
        bus5.stop    = 1'b0;
        bus5.ready   = 1'b0;
        bus0.start   = 1'b0;
        bus0.stop    = 1'b0;
        bus0.ready   = 1'b0;

        test_reset();
        test_full_sweep();
        test_backpressure();
        test_abort();
        test_corners();
        test_no_hold();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
